// File: rtl/mux2_arb_pkg.sv
// Shared types and the round-robin owner selection used by the mux2 arbiter.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Pick the next owner; on contention the requester not served last wins.
    function automatic state_t next_owner(input logic req0, input logic req1,
                                          input logic last_served);
        state_t w_owner;
        if (req0 && req1) begin
            w_owner = last_served ? OWN0 : OWN1;
        end else if (req0) begin
            w_owner = OWN0;
        end else if (req1) begin
            w_owner = OWN1;
        end else begin
            w_owner = IDLE;
        end
        return w_owner;
    endfunction

endpackage

// File: rtl/mux2.sv
// Single-bit 2:1 multiplexer cell: select=0 passes in0, select=1 passes in1.
module mux2 (
    input  logic select,
    input  logic in0,
    input  logic in1,
    output logic out
);

    assign out = select ? in1 : in0;

endmodule

// File: rtl/mux2_arbiter_datapath.sv
// Shared datapath: WIDTH data bits plus the last flag, each steered by one mux2 cell.
module mux2_arbiter_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             i_select,
    input  logic [WIDTH-1:0] i_in0,
    input  logic [WIDTH-1:0] i_in1,
    input  logic             i_last0,
    input  logic             i_last1,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last
);

    logic [WIDTH:0] w_a;
    logic [WIDTH:0] w_b;
    logic [WIDTH:0] w_y;

    assign w_a = {i_last0, i_in0};
    assign w_b = {i_last1, i_in1};

    for (genvar g = 0; g <= WIDTH; g++) begin : g_bit
        mux2 u_mux2 (
            .select (i_select),
            .in0    (w_a[g]),
            .in1    (w_b[g]),
            .out    (w_y[g])
        );
    end

    assign o_data = w_y[WIDTH-1:0];
    assign o_last = w_y[WIDTH];

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin burst arbiter owning the select of a shared mux2 datapath between two
// requesters, with valid/ready output and forced re-arbitration after MAX_BEATS beats.
module mux2_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             last0,
    input  logic             last1,
    input  logic             out_ready,
    output logic             grant0,
    output logic             grant1,
    output logic             select,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             preempt
);

    localparam int               CNT_W    = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_t           r_state;
    logic             r_grant0;
    logic             r_grant1;
    logic             r_select;
    logic             r_preempt;
    logic             r_last_served;
    logic [CNT_W-1:0] r_beat_cnt;

    state_t           w_next_state;
    logic             w_own_req;
    logic             w_own_last;
    logic             w_owner_id;
    logic             w_valid;
    logic             w_beat;
    logic             w_burst_end;
    logic             w_preempt_next;
    logic             w_last_served_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [WIDTH-1:0] w_mux_data;
    logic             w_mux_last;

    mux2_arbiter_datapath #(.WIDTH(WIDTH)) u_datapath (
        .i_select (r_select),
        .i_in0    (in0),
        .i_in1    (in1),
        .i_last0  (last0),
        .i_last1  (last1),
        .o_data   (w_mux_data),
        .o_last   (w_mux_last)
    );

    // Request and last flag of whichever requester currently owns the datapath.
    always_comb begin
        w_own_req  = 1'b0;
        w_own_last = 1'b0;
        w_owner_id = 1'b0;
        case (r_state)
            OWN0: begin
                w_own_req  = req0;
                w_own_last = last0;
                w_owner_id = 1'b0;
            end
            OWN1: begin
                w_own_req  = req1;
                w_own_last = last1;
                w_owner_id = 1'b1;
            end
            default: begin
                w_own_req  = 1'b0;
                w_own_last = 1'b0;
                w_owner_id = 1'b0;
            end
        endcase
    end

    // A reset cycle never transfers a beat, even mid-burst.
    assign w_valid = ((r_grant0 & req0) | (r_grant1 & req1)) & ~reset;
    assign w_beat  = w_valid & out_ready;

    // Burst-end detection, beat counting and next owner selection.
    always_comb begin
        w_next_state       = r_state;
        w_burst_end        = 1'b0;
        w_preempt_next     = 1'b0;
        w_cnt_next         = r_beat_cnt;
        w_last_served_next = r_last_served;
        if (r_state == IDLE) begin
            w_next_state = next_owner(req0, req1, r_last_served);
        end else begin
            if (!w_own_req) begin
                w_burst_end = 1'b1;
            end else if (w_beat && (w_own_last || (r_beat_cnt == CNT_LAST))) begin
                w_burst_end    = 1'b1;
                w_preempt_next = ~w_own_last;
            end else if (w_beat) begin
                w_cnt_next = r_beat_cnt + CNT_ONE;
            end else begin
                w_cnt_next = r_beat_cnt;
            end
            // Passing the finishing owner as last_served gives the other side priority.
            if (w_burst_end) begin
                w_cnt_next         = CNT_ZERO;
                w_last_served_next = w_owner_id;
                w_next_state       = next_owner(req0, req1, w_owner_id);
            end else begin
                w_next_state = r_state;
            end
        end
    end

    // State, grants, select, counter and preempt pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_grant0      <= 1'b0;
            r_grant1      <= 1'b0;
            r_select      <= 1'b0;
            r_preempt     <= 1'b0;
            r_last_served <= 1'b1;
            r_beat_cnt    <= CNT_ZERO;
        end else begin
            r_state       <= w_next_state;
            r_grant0      <= (w_next_state == OWN0);
            r_grant1      <= (w_next_state == OWN1);
            r_preempt     <= w_preempt_next;
            r_last_served <= w_last_served_next;
            r_beat_cnt    <= w_cnt_next;
            case (w_next_state)
                OWN0:    r_select <= 1'b0;
                OWN1:    r_select <= 1'b1;
                default: r_select <= r_select;
            endcase
        end
    end

    assign grant0    = r_grant0;
    assign grant1    = r_grant1;
    assign select    = r_select;
    assign preempt   = r_preempt;
    assign out_valid = w_valid;
    assign out_data  = (r_state == IDLE) ? {WIDTH{1'b0}} : w_mux_data;
    assign out_last  = (r_state == IDLE) ? 1'b0 : w_mux_last;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scenario-driven bench for mux2_arbiter: expected beats are queued as stimulus is
// driven and popped when the arbiter presents an accepted beat.
module tb_mux2_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [7:0] in0, in1;
    logic       last0, last1;
    logic       out_ready;
    logic       grant0, grant1, select, out_valid, out_last, preempt;
    logic [7:0] out_data;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] sb_q[$];
    logic [8:0] exp_beat;

    always #5 clk = ~clk;

    mux2_arbiter #(.WIDTH(8), .MAX_BEATS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .in0       (in0),
        .in1       (in1),
        .last0     (last0),
        .last1     (last1),
        .out_ready (out_ready),
        .grant0    (grant0),
        .grant1    (grant1),
        .select    (select),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .preempt   (preempt)
    );

    task automatic do_reset();
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
        in0 = 8'h00; in1 = 8'h00; out_ready = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req0 = 1'b1; req1 = 1'b1; in0 = 8'h5A; in1 = 8'hC3;
        last0 = 1'b1; last1 = 1'b1; out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            n_checks++;
            if ({grant0, grant1, select, out_valid, out_data, out_last, preempt} !== 14'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got g0=%b g1=%b sel=%b v=%b d=%h l=%b p=%b, want all 0",
                         grant0, grant1, select, out_valid, out_data, out_last, preempt);
            end
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({grant0, grant1, select} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_first_grant: got g0g1sel=%b%b%b want 100", grant0, grant1, select);
        end
    endtask

    task automatic test_burst();
        logic [7:0] beats [3];
        int idx;
        beats[0] = 8'hA1; beats[1] = 8'hA2; beats[2] = 8'hA3;
        do_reset();
        for (int k = 0; k < 3; k++) sb_q.push_back({(k == 2) ? 1'b1 : 1'b0, beats[k]});
        req0 = 1'b1; out_ready = 1'b1; idx = 0;
        for (int cyc = 0; cyc < 20 && sb_q.size() > 0; cyc++) begin
            in0 = (idx < 3) ? beats[idx] : 8'hFF;
            last0 = (idx == 2);
            #1;
            if (out_valid && out_ready) begin
                exp_beat = sb_q.pop_front();
                n_checks++;
                if ({out_last, out_data} !== exp_beat) begin
                    n_fail++;
                    $display("FAIL burst_beat%0d: got last=%b data=%h want last=%b data=%h",
                             idx, out_last, out_data, exp_beat[8], exp_beat[7:0]);
                end
                idx++;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL burst_timeout: %0d beats still outstanding, want 0", sb_q.size());
        end
        req0 = 1'b0; last0 = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({grant0, grant1, out_valid, out_data} !== 11'd0) begin
            n_fail++;
            $display("FAIL burst_idle: got g0=%b g1=%b v=%b d=%h want idle zeros",
                     grant0, grant1, out_valid, out_data);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        req0 = 1'b1; req1 = 1'b1; last0 = 1'b1; last1 = 1'b1;
        in0 = 8'h3C; in1 = 8'hC5; out_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back({1'b1, (i % 2 == 1) ? 8'hC5 : 8'h3C});
            n_checks++;
            if ({grant0, grant1, select} !== ((i % 2 == 1) ? 3'b011 : 3'b100)) begin
                n_fail++;
                $display("FAIL alt_grant%0d: got g0g1sel=%b%b%b want %s", i, grant0, grant1,
                         select, (i % 2 == 1) ? "011" : "100");
            end
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL alt_valid%0d: got %b want 1", i, out_valid);
            end else begin
                exp_beat = sb_q.pop_front();
                if ({out_last, out_data} !== exp_beat) begin
                    n_fail++;
                    $display("FAIL alt_data%0d: got %h want %h", i, {out_last, out_data}, exp_beat);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_preempt();
        do_reset();
        req1 = 1'b1; last1 = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            in1 = 8'h70 + 8'(k);
            sb_q.push_back({1'b0, 8'h70 + 8'(k)});
            #1;
            n_checks++;
            if (preempt !== 1'b0 || grant1 !== 1'b1 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL pre_beat%0d: got p=%b g1=%b v=%b want p=0 g1=1 v=1",
                         k, preempt, grant1, out_valid);
            end else begin
                exp_beat = sb_q.pop_front();
                if ({out_last, out_data} !== exp_beat) begin
                    n_fail++;
                    $display("FAIL pre_data%0d: got %h want %h", k, {out_last, out_data}, exp_beat);
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (preempt !== 1'b1 || grant1 !== 1'b1 || grant0 !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_pulse: got p=%b g0=%b g1=%b want p=1 g0=0 g1=1", preempt, grant0, grant1);
        end
        @(posedge clk); #1;
        n_checks++;
        if (preempt !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_oneshot: got p=%b want 0", preempt);
        end
    endtask

    task automatic test_stall();
        do_reset();
        req0 = 1'b1; last0 = 1'b0; out_ready = 1'b1; in0 = 8'hA1;
        @(posedge clk); #1;
        sb_q.push_back({1'b0, 8'hA1});
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_first_valid: got %b want 1", out_valid);
        end else begin
            exp_beat = sb_q.pop_front();
            if ({out_last, out_data} !== exp_beat) begin
                n_fail++;
                $display("FAIL stall_first_data: got %h want %h", {out_last, out_data}, exp_beat);
            end
        end
        @(posedge clk); #1;
        in0 = 8'hB2; out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'hB2 || grant0 !== 1'b1 || preempt !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got v=%b d=%h g0=%b p=%b want v=1 d=b2 g0=1 p=0",
                         s, out_valid, out_data, grant0, preempt);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in0 = 8'hB2 + 8'(k);
            sb_q.push_back({1'b0, 8'hB2 + 8'(k)});
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || preempt !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_resume%0d: got v=%b p=%b want v=1 p=0", k, out_valid, preempt);
            end else begin
                exp_beat = sb_q.pop_front();
                if ({out_last, out_data} !== exp_beat) begin
                    n_fail++;
                    $display("FAIL stall_data%0d: got %h want %h", k, {out_last, out_data}, exp_beat);
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (preempt !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_count: got preempt=%b after 4 beats, want 1", preempt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0 = 1'b1; in0 = 8'hA1; last0 = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        sb_q.push_back({1'b1, 8'hA1});
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_valid: got %b want 1", out_valid);
        end else begin
            exp_beat = sb_q.pop_front();
            if ({out_last, out_data} !== exp_beat) begin
                n_fail++;
                $display("FAIL mid_data: got %h want %h", {out_last, out_data}, exp_beat);
            end
        end
        @(posedge clk); #1;
        in0 = 8'hA2; last0 = 1'b0; reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_no_beat: got out_valid=%b in reset cycle want 0", out_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (grant0 !== 1'b0 || grant1 !== 1'b0 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_idle: got g0=%b g1=%b d=%h want 0 0 00", grant0, grant1, out_data);
        end
        reset = 1'b0; req1 = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (grant0 !== 1'b1 || grant1 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rearb: got g0=%b g1=%b want g0=1 g1=0", grant0, grant1);
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_alternate();
        test_preempt();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
